// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the ranged LFSR random source.
// Holds the FSM state encoding, the default tap mask and the range-mask function.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } lfsr_state_e;

    // Default taps for x^6 + x^5 + 1 (maximal period 63).
    localparam logic [5:0] LFSR6_TAPS = 6'b110000;

    localparam int MASK_W = 32;

    // Smallest 2^k-1 covering limit-1; limit 0 means the full range.
    function automatic logic [MASK_W-1:0] range_mask(input logic [MASK_W-1:0] limit);
        logic [MASK_W-1:0] target;
        logic [MASK_W-1:0] m;
        if (limit == 32'd0) begin
            m = {MASK_W{1'b1}};
        end else begin
            target = limit - 32'd1;
            m      = 32'd0;
            for (int i = 0; i < MASK_W; i++) begin
                if (m < target) begin
                    m = {m[MASK_W-2:0], 1'b1};
                end else begin
                    m = m;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed loading and zero-state protection.
// Load has priority over stepping; any zero result is replaced by SEED.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 6,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR6_TAPS),
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] lfsr_r;
    logic [WIDTH-1:0] cand_s;
    logic [WIDTH-1:0] next_s;

    // Next-state selection: load wins over step; zero is never allowed into the register.
    always_comb begin
        cand_s = lfsr_r;
        if (load) begin
            cand_s = load_val;
        end else if (step) begin
            cand_s = {lfsr_r[WIDTH-2:0], ^(lfsr_r & TAPS)};
        end else begin
            cand_s = lfsr_r;
        end
        if (cand_s == {WIDTH{1'b0}}) begin
            next_s = SEED;
        end else begin
            next_s = cand_s;
        end
    end

    // LFSR state register with synchronous reset to SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= next_s;
        end
    end

    assign state = lfsr_r;

endmodule

// File: rtl/lfsr_range_random.sv
// Ranged pseudo-random source: rejection-samples masked LFSR states into [0, limit-1].
// One request at a time; valid pulses for one cycle when value is updated.
module lfsr_range_random
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 6,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR6_TAPS),
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] raw
);

    lfsr_state_e      state_r;
    lfsr_state_e      state_s;
    logic [WIDTH-1:0] lfsr_s;
    logic [WIDTH-1:0] lim_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] value_r;
    logic [WIDTH-1:0] cand_s;
    logic             accept_s;
    logic             step_s;

    // Drawing forces a step every cycle; otherwise the generator free-runs under en.
    assign step_s = en | (state_r == DRAW);

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .step     (step_s),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (lfsr_s)
    );

    assign mask_s = WIDTH'(range_mask(MASK_W'(limit)));

    // Candidate is taken from the pre-step state and tested against the latched bound.
    always_comb begin
        cand_s   = lfsr_s & mask_r;
        accept_s = (lim_r == {WIDTH{1'b0}}) || (cand_s < lim_r);
    end

    // Next-state logic for the request handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_s = DRAW;
                end else begin
                    state_s = IDLE;
                end
            end
            DRAW: begin
                if (accept_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAW;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bound/mask latch on request acceptance and result register on draw acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            lim_r   <= {WIDTH{1'b0}};
            mask_r  <= {WIDTH{1'b0}};
            value_r <= {WIDTH{1'b0}};
        end else begin
            if ((state_r == IDLE) && req) begin
                lim_r  <= limit;
                mask_r <= mask_s;
            end
            if ((state_r == DRAW) && accept_s) begin
                value_r <= cand_s;
            end
        end
    end

    assign ready = (state_r == IDLE);
    assign valid = (state_r == DONE);
    assign value = value_r;
    assign raw   = lfsr_s;

endmodule

// File: tb/tb_lfsr_range_random.sv
// Self-checking bench for lfsr_range_random: directed literal checks plus a
// randomized request sweep compared every cycle against a behavioural model.
module tb_lfsr_range_random;

    localparam int W    = 6;
    localparam int TAPS = 6'b110000;
    localparam int SEED = 63;

    logic         clk;
    logic         rst;
    logic         en;
    logic         seed_load;
    logic [W-1:0] seed_in;
    logic         req;
    logic [W-1:0] limit;
    logic         ready;
    logic         valid;
    logic [W-1:0] value;
    logic [W-1:0] raw;

    int tests;
    int fails;

    // Behavioural model: generator value, request phase (0 idle, 1 drawing, 2 result cycle), result.
    int m_lfsr;
    int m_phase;
    int m_lim;
    int m_mask;
    int m_value;

    lfsr_range_random dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .limit     (limit),
        .ready     (ready),
        .valid     (valid),
        .value     (value),
        .raw       (raw)
    );

    always #5 clk = ~clk;

    function automatic int mstep(input int s);
        int fb;
        fb = 0;
        for (int i = 0; i < W; i++) begin
            if (((TAPS >> i) & 1) == 1) fb = fb ^ ((s >> i) & 1);
        end
        return ((s * 2) % (1 << W)) + fb;
    endfunction

    function automatic int mmask(input int lim);
        if (lim == 0) return (1 << W) - 1;
        for (int k = 0; k <= W; k++) begin
            if ((1 << k) - 1 >= lim - 1) return (1 << k) - 1;
        end
        return (1 << W) - 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_advance();
        int nl;
        int cand;
        if (rst) begin
            m_lfsr  = SEED;
            m_phase = 0;
            m_lim   = 0;
            m_mask  = 0;
            m_value = 0;
        end else begin
            nl = (m_phase == 1 || en) ? mstep(m_lfsr) : m_lfsr;
            if (seed_load) nl = (seed_in == 0) ? SEED : int'(seed_in);
            if (m_phase == 0) begin
                if (req) begin
                    m_lim   = limit;
                    m_mask  = mmask(limit);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                cand = m_lfsr & m_mask;
                if (m_lim == 0 || cand < m_lim) begin
                    m_value = cand;
                    m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
            m_lfsr = nl;
        end
    endtask

    task automatic compare_all();
        check("raw", raw, m_lfsr);
        check("raw_nonzero", raw != 0, 1);
        check("ready", ready, m_phase == 0);
        check("valid", valid, m_phase == 2);
        check("value", value, m_value);
    endtask

    // One clock: update model with current inputs, let the edge pass, compare at negedge.
    task automatic tick();
        model_advance();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; seed_load = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int seq[8];
        int p;
        int n;
        int lim;
        seq = '{63, 62, 60, 56, 48, 32, 1, 2};
        tests = 0; fails = 0;
        clk = 1'b0; rst = 1'b1; en = 1'b1; seed_load = 1'b0;
        seed_in = 6'd0; req = 1'b0; limit = 6'd0;
        m_lfsr = SEED; m_phase = 0; m_lim = 0; m_mask = 0; m_value = 0;
        @(negedge clk);

        // Reset state and free-run sequence.
        do_reset();
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_value", value, 0);
        for (int i = 0; i < 8; i++) begin
            check("freerun", raw, seq[i]);
            tick();
        end
        p = 8;
        while (raw !== 6'd63 && p < 200) begin
            tick();
            p++;
        end
        check("period", p, 63);

        // Full range: value 63 at T+2, ready back at T+3.
        en = 1'b0;
        do_reset();
        req = 1'b1; limit = 6'd0;
        tick();
        req = 1'b0;
        check("full_busy", ready, 0);
        tick();
        check("full_valid", valid, 1);
        check("full_value", value, 63);
        tick();
        check("full_ready", ready, 1);
        check("full_valid_off", valid, 0);

        // Rejection: candidates 15,14,12 rejected, 8 accepted at T+5.
        do_reset();
        req = 1'b1; limit = 6'd10;
        tick();
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rej_wait", valid, 0);
        end
        tick();
        check("rej_valid", valid, 1);
        check("rej_value", value, 8);
        check("rej_raw", raw, 48);

        // Seed handling.
        tick();
        seed_load = 1'b1; seed_in = 6'd0; en = 1'b1;
        tick();
        check("seed_zero", raw, 63);
        seed_in = 6'd5;
        tick();
        check("seed_wins", raw, 5);
        seed_load = 1'b0; en = 1'b0;

        // Seed mid-draw: first candidate 15 rejected, next comes from seed 5.
        do_reset();
        req = 1'b1; limit = 6'd10;
        tick();
        req = 1'b1; seed_load = 1'b1; seed_in = 6'd5;
        tick();
        seed_load = 1'b0;
        check("mid_seed_raw", raw, 5);
        tick();
        check("mid_seed_valid", valid, 1);
        check("mid_seed_value", value, 5);
        // Request while busy (result cycle) must be ignored.
        tick();
        check("busy_ignored_ready", ready, 1);
        check("busy_ignored_valid", valid, 0);

        // Reset mid-draw clears everything with no valid pulse.
        req = 1'b1; limit = 6'd10;
        tick();
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_draw_valid", valid, 0);
        check("rst_draw_value", value, 0);
        check("rst_draw_raw", raw, 63);
        check("rst_draw_ready", ready, 1);

        // Randomized sweep.
        for (int r = 0; r < 3000; r++) begin
            en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                seed_load = 1'b1;
                seed_in = W'($urandom_range(0, 63));
                tick();
                seed_load = 1'b0;
            end
            lim = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) lim = 1;
            limit = W'(lim);
            req = 1'b1;
            tick();
            req = 1'b0;
            limit = W'($urandom_range(0, 63));
            n = 0;
            while (valid !== 1'b1 && n < 200) begin
                en = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            check("sweep_done", valid, 1);
            check("sweep_draw_len", n <= 63, 1);
            if (lim == 0) check("sweep_full_nonzero", value != 0, 1);
            else check("sweep_in_range", value < lim, 1);
            if (lim == 1) begin
                check("sweep_lim1_value", value, 0);
                check("sweep_lim1_latency", n + 1, 2);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
